razzle_scheduler: RTL

Frame-level controller for the razzle pattern display path. Samples vertical sync in the pixel-clock domain and produces a one-cycle frame tick. Owns the per-frame dither offset and rotates the active pattern on a dwell timer or on user request, inserting blank frames between patterns. Honours a stop/pause request. Sits between the VGA timing generator and the pattern datapaths; its outputs feed pattern selection, dither and blanking.

---
 rtl/razzle_scheduler_if.sv | 24 ++
 rtl/razzle_scheduler.sv | 121 ++++++++++++
 2 files changed

// File: rtl/razzle_scheduler_if.sv
// Frame-control bundle between the VGA timing side and the razzle scheduler.
// The master side drives sync and user requests; the slave side returns
// pattern selection, dither and blanking controls.
interface razzle_scheduler_if;
  logic        VGA_V_SYNC;
  logic        stop;
  logic        next;
  logic        auto_en;
  logic [1:0]  pattern_sel;
  logic [15:0] dither;
  logic        blank;
  logic        frame_tick;
  logic [1:0]  state;

  modport master (
    output VGA_V_SYNC, stop, next, auto_en,
    input  pattern_sel, dither, blank, frame_tick, state
  );

  modport slave (
    input  VGA_V_SYNC, stop, next, auto_en,
    output pattern_sel, dither, blank, frame_tick, state
  );
endinterface

// File: rtl/razzle_scheduler.sv
// Frame-level controller for the razzle pattern path: synchronises vsync into
// a one-cycle frame tick, owns the dither offset and rotates patterns with
// blank frames in between, on a dwell timer or on a user "next" request.
//
// state | meaning
// ------+-----------------------------------------------------------
// SHOW  | pattern displayed; dither and dwell advance each frame
// PAUSE | stop requested; dither and dwell frozen
// BLANK | display forced black between patterns; dither frozen
module razzle_scheduler #(
  parameter logic [15:0] DWELL_FRAMES = 16'd300,
  parameter logic [3:0]  BLANK_FRAMES = 4'd2,
  parameter logic [2:0]  NUM_PATTERNS = 3'd4,
  parameter logic [15:0] DITHER_STEP  = 16'd1
) (
  input logic               iCLK,
  input logic               iRST,
  razzle_scheduler_if.slave bus
);

  localparam logic [1:0]  ST_SHOW    = 2'b00;
  localparam logic [1:0]  ST_PAUSE   = 2'b01;
  localparam logic [1:0]  ST_BLANK   = 2'b10;
  localparam logic [15:0] DWELL_LAST = DWELL_FRAMES - 16'd1;
  localparam logic [3:0]  BLANK_LAST = BLANK_FRAMES - 4'd1;
  localparam logic [2:0]  PAT_LAST   = NUM_PATTERNS - 3'd1;

  logic        s1, s2, s3;
  logic        frame_tick;
  logic [1:0]  state;
  logic [1:0]  pattern_sel;
  logic [15:0] dither;
  logic [15:0] dwell_cnt;
  logic [3:0]  blank_cnt;
  logic        blank;
  logic        next_pending;
  logic        rotate;
  logic        consume;

  // A pulse arriving on the tick itself counts as already pending.
  assign rotate  = next_pending | bus.next |
                   (bus.auto_en & (dwell_cnt == DWELL_LAST));
  // Pending request is used up exactly when SHOW hands over to BLANK.
  assign consume = frame_tick & (state == ST_SHOW) & ~bus.stop & rotate;

  // Two-flop synchroniser plus history flop; registered rising-edge tick.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      s1         <= bus.VGA_V_SYNC;
      s2         <= s1;
      s3         <= s2;
      frame_tick <= s2 & ~s3;
    end
  end

  // Sticky next request; repeated pulses collapse into one advance.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)          next_pending <= 1'b0;
    else if (consume)  next_pending <= 1'b0;
    else if (bus.next) next_pending <= 1'b1;
  end

  // Frame-rate sequencing: all state and counters move only on frame_tick.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state       <= ST_SHOW;
      pattern_sel <= 2'd0;
      dither      <= 16'd0;
      dwell_cnt   <= 16'd0;
      blank_cnt   <= 4'd0;
      blank       <= 1'b0;
    end else if (frame_tick) begin
      case (state)
        ST_SHOW: begin
          if (bus.stop) begin
            state <= ST_PAUSE;
          end else if (rotate) begin
            state     <= ST_BLANK;
            blank     <= 1'b1;
            blank_cnt <= 4'd0;
          end else begin
            dither <= dither + DITHER_STEP;
            // Saturate so a disabled timer cannot run past the trigger value.
            if (dwell_cnt != DWELL_LAST) dwell_cnt <= dwell_cnt + 16'd1;
          end
        end
        ST_PAUSE: begin
          if (!bus.stop) state <= ST_SHOW;
        end
        ST_BLANK: begin
          // stop is deliberately ignored so a blank sequence always finishes.
          if (blank_cnt == BLANK_LAST) begin
            pattern_sel <= ({1'b0, pattern_sel} == PAT_LAST) ? 2'd0
                                                              : pattern_sel + 2'd1;
            dwell_cnt   <= 16'd0;
            blank       <= 1'b0;
            state       <= ST_SHOW;
          end else begin
            blank_cnt <= blank_cnt + 4'd1;
          end
        end
        default: begin
          state <= ST_SHOW;
          blank <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pattern_sel = pattern_sel;
  assign bus.dither      = dither;
  assign bus.blank       = blank;
  assign bus.frame_tick  = frame_tick;
  assign bus.state       = state;

endmodule
